// File: rtl/prm_edge_query_seq.sv
// Sweeps a range of query vectors onto a PRM obstacle checker, packs the 1-bit
// answers into PW-bit words and streams them out over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; base/count sampled here only
// ST_RUN   | one query issued and sampled per unstalled cycle
// ST_DRAIN | all queries sampled; waiting for the last word handshake
// ST_FIN   | done pulse; busy drops on leaving
module prm_edge_query_seq #(
   parameter int QW = 15,
   parameter int PW = 32
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [QW-1:0] base_i,
   input  logic [15:0]   count_i,
   output logic [QW-1:0] query_o,
   input  logic          mask_in_i,
   output logic [PW-1:0] res_data_o,
   output logic          res_valid_o,
   input  logic          res_ready_i,
   output logic          res_last_o,
   output logic [15:0]   hit_cnt_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam int IW = $clog2(PW);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FIN} state_t;

   state_t        state_q, state_d;
   logic [QW-1:0] query_q, query_d;
   logic [15:0]   remain_q, remain_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [PW-1:0] pack_q, pack_d;
   logic [PW-1:0] res_data_q, res_data_d;
   logic          res_valid_q, res_valid_d;
   logic          res_last_q, res_last_d;
   logic [15:0]   hit_cnt_q, hit_cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [PW-1:0] pack_new;
   logic          last_sample;
   logic          word_end;
   logic          out_free;
   logic          accept;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         query_q     <= '0;
         remain_q    <= '0;
         idx_q       <= '0;
         pack_q      <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         hit_cnt_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         query_q     <= query_d;
         remain_q    <= remain_d;
         idx_q       <= idx_d;
         pack_q      <= pack_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         res_last_q  <= res_last_d;
         hit_cnt_q   <= hit_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      query_d     = query_q;
      remain_d    = remain_q;
      idx_d       = idx_q;
      pack_d      = pack_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
      hit_cnt_d   = hit_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;

      pack_new        = pack_q;
      pack_new[idx_q] = mask_in_i;
      last_sample     = (remain_q == 16'd1);
      word_end        = (idx_q == IW'(PW - 1)) || last_sample;
      out_free        = !res_valid_q || res_ready_i;
      accept          = res_valid_q && res_ready_i;

      if (accept) begin
         res_valid_d = 1'b0;
         res_last_d  = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               query_d   = base_i;
               remain_d  = count_i;
               hit_cnt_d = '0;
               pack_d    = '0;
               idx_d     = '0;
               busy_d    = 1'b1;
               if (count_i == 16'd0) begin
                  state_d = ST_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // A completing sample is withheld until the output register can
            // take the word; the checker answer is simply re-read next cycle.
            if (!word_end || out_free) begin
               hit_cnt_d = hit_cnt_q + 16'(mask_in_i);
               query_d   = query_q + QW'(1);
               remain_d  = remain_q - 16'd1;
               if (word_end) begin
                  res_data_d  = pack_new;
                  res_valid_d = 1'b1;
                  res_last_d  = last_sample;
                  pack_d      = '0;
                  idx_d       = '0;
                  if (last_sample) state_d = ST_DRAIN;
               end else begin
                  pack_d = pack_new;
                  idx_d  = idx_q + IW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (accept && res_last_q) begin
               state_d = ST_FIN;
               done_d  = 1'b1;
            end
         end
         ST_FIN: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign query_o     = query_q;
   assign res_data_o  = res_data_q;
   assign res_valid_o = res_valid_q;
   assign res_last_o  = res_last_q;
   assign hit_cnt_o   = hit_cnt_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Bench for prm_edge_query_seq: table of sweeps checked against a per-query
// reference model, plus hand sequences for stall and mid-sweep reset.
module tb_prm_edge_query_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [14:0] base = '0;
   logic [15:0] count = '0;
   logic [14:0] query;
   logic        mask_in;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic        res_last;
   logic [15:0] hit_cnt;
   logic        busy;
   logic        done;

   int mode = 0;
   bit lut [32768];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   prm_edge_query_seq #(.QW(15), .PW(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_i(base),
      .count_i(count), .query_o(query), .mask_in_i(mask_in),
      .res_data_o(res_data), .res_valid_o(res_valid), .res_ready_i(res_ready),
      .res_last_o(res_last), .hit_cnt_o(hit_cnt), .busy_o(busy), .done_o(done)
   );

   // checker model: 0 -> query[0], 1 -> always hit, 2 -> random table
   always_comb begin
      case (mode)
         0:       mask_in = query[0];
         1:       mask_in = 1'b1;
         2:       mask_in = lut[query];
         default: mask_in = 1'b0;
      endcase
   end

   function automatic bit ref_bit(int m, int q);
      case (m)
         0:       return q[0];
         1:       return 1'b1;
         2:       return lut[q];
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // handshake monitor and hold-while-stalled check
   logic [31:0] got_w[$];
   bit          got_l[$];
   bit          stall_prev = 1'b0;
   logic [31:0] data_prev = '0;

   always @(posedge clk) begin
      if (rst_n) begin
         if (stall_prev) begin
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_data", 64'(res_data), 64'(data_prev));
         end
         if (res_valid && res_ready) begin
            got_w.push_back(res_data);
            got_l.push_back(res_last);
         end
         stall_prev = res_valid && !res_ready;
         data_prev  = res_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic check_words(int b, int n, int m, int exp_nw, int exp_hits, longint exp_w0);
      logic [31:0] ew[$];
      logic [31:0] w;
      int h;
      w = '0;
      h = 0;
      for (int i = 0; i < n; i++) begin
         bit r;
         r = ref_bit(m, (b + i) % 32768);
         w[i % 32] = r;
         h += int'(r);
         if ((i % 32) == 31 || i == n - 1) begin
            ew.push_back(w);
            w = '0;
         end
      end
      chk("hit_cnt", 64'(hit_cnt), 64'(h));
      if (exp_hits >= 0) chk("hit_cnt_tbl", 64'(hit_cnt), 64'(exp_hits));
      chk("n_words", 64'(got_w.size()), 64'(ew.size()));
      chk("n_words_tbl", 64'(got_w.size()), 64'(exp_nw));
      if (exp_w0 >= 0 && got_w.size() > 0) chk("word0_tbl", 64'(got_w[0]), 64'(exp_w0));
      for (int i = 0; i < ew.size() && i < got_w.size(); i++) begin
         chk($sformatf("word%0d", i), 64'(got_w[i]), 64'(ew[i]));
         chk($sformatf("last%0d", i), 64'(got_l[i]), 64'(i == ew.size() - 1));
      end
   endtask

   task automatic wait_done(bit rdy_rand, bit restart, int b);
      int cyc = 0;
      while (!done && cyc < 40000) begin
         if (restart && cyc == 5) begin
            start = 1'b1;
            base  = 15'(b + 100);
         end else begin
            start = 1'b0;
         end
         res_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      res_ready = 1'b1;
      if (!done) chk("done_timeout", 64'(done), 64'd1);
   endtask

   task automatic run_sweep(int b, int n, int m, bit rdy_rand, bit restart,
                            int exp_nw, int exp_hits, longint exp_w0);
      mode = m;
      @(negedge clk);
      got_w.delete();
      got_l.delete();
      base  = 15'(b);
      count = 16'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("query_eq_base", 64'(query), 64'(b));
      if (n == 0) chk("done_zero_count", 64'(done), 64'd1);
      wait_done(rdy_rand, restart, b);
      check_words(b, n, m, exp_nw, exp_hits, exp_w0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("hit_cnt_hold", 64'(hit_cnt), 64'(got_w.size() > 0 ? hit_cnt : 16'd0));
   endtask

   typedef struct {
      int     b;
      int     n;
      int     m;
      bit     rdy_rand;
      bit     restart;
      int     exp_nw;
      int     exp_hits;
      longint exp_w0;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [15:0] hc;
      for (int i = 0; i < 32768; i++) lut[i] = bit'($urandom_range(0, 1));

      tbl.push_back('{32'h0000, 32, 0, 1'b0, 1'b0, 1, 16, 64'hAAAAAAAA});
      tbl.push_back('{32'h7FF0, 40, 1, 1'b0, 1'b0, 2, 40, 64'hFFFFFFFF});
      tbl.push_back('{32'h0100, 0,  1, 1'b0, 1'b0, 0, 0,  -1});
      tbl.push_back('{32'h7FFF, 1,  1, 1'b0, 1'b0, 1, 1,  64'h00000001});
      tbl.push_back('{32'h0010, 33, 0, 1'b1, 1'b0, 2, 16, 64'hAAAAAAAA});
      tbl.push_back('{32'h0123, 96, 2, 1'b0, 1'b1, 3, -1, -1});
      tbl.push_back('{32'h4000, 32768, 2, 1'b0, 1'b0, 1024, -1, -1});
      for (int i = 0; i < 6; i++) begin
         int n;
         n = int'($urandom_range(1, 200));
         tbl.push_back('{int'($urandom_range(0, 32767)), n, 2, 1'b1, 1'b0,
                         (n + 31) / 32, -1, -1});
      end

      // reset values
      #12;
      chk("rst_query", 64'(query), 64'd0);
      chk("rst_res_data", 64'(res_data), 64'd0);
      chk("rst_valid", 64'(res_valid), 64'd0);
      chk("rst_last", 64'(res_last), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // mid-sweep asynchronous reset
      mode = 1;
      @(negedge clk);
      base = 15'h0200; count = 16'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_query", 64'(query), 64'd0);
      chk("mid_rst_res_data", 64'(res_data), 64'd0);
      chk("mid_rst_valid", 64'(res_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_hit_cnt", 64'(hit_cnt), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i])
         run_sweep(tbl[i].b, tbl[i].n, tbl[i].m, tbl[i].rdy_rand, tbl[i].restart,
                   tbl[i].exp_nw, tbl[i].exp_hits, tbl[i].exp_w0);

      // backpressure long enough to stall issue: query must freeze at 63
      mode = 0;
      @(negedge clk);
      got_w.delete();
      got_l.delete();
      base = 15'h0000; count = 16'd96; start = 1'b1; res_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 32; k++) @(negedge clk);
      chk("bp_no_valid_early", 64'(res_valid), 64'd0);
      @(negedge clk);
      chk("bp_first_valid", 64'(res_valid), 64'd1);
      chk("bp_first_data", 64'(res_data), 64'hAAAAAAAA);
      res_ready = 1'b0;
      repeat (40) @(negedge clk);
      chk("bp_query_frozen", 64'(query), 64'd63);
      hc = hit_cnt;
      chk("bp_hit_frozen", 64'(hc), 64'd31);
      @(negedge clk);
      chk("bp_query_still", 64'(query), 64'd63);
      chk("bp_data_held", 64'(res_data), 64'hAAAAAAAA);
      wait_done(1'b0, 1'b0, 0);
      check_words(0, 96, 0, 3, 48, 64'hAAAAAAAA);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
